// File: rtl/pkt_rate_shaper_pkg.sv
// Shared types and constants for the packet-rate shaper: FSM encoding,
// input FIFO depth, statistics counter width and token arithmetic helper.
package pkt_rate_shaper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HDR  = 2'b01,
        ST_BODY = 2'b10,
        ST_HOLD = 2'b11
    } shaper_state_e;

    localparam int MAX_DEPTH_BITS = 2;
    localparam int CNT_WIDTH      = 32;
    localparam int TOK_WIDTH      = 8;

    function automatic logic [TOK_WIDTH-1:0] tok_sat_inc(
        input logic [TOK_WIDTH-1:0] level,
        input logic [TOK_WIDTH-1:0] max_level
    );
        return (level >= max_level) ? max_level : level + TOK_WIDTH'(1);
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: the head entry is visible on dout_o
// whenever empty_o is low, and rd_en_i pops it at the clock edge.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             nearly_full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] DEPTH_C = (MAX_DEPTH_BITS + 1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] NF_LVL  = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [MAX_DEPTH_BITS:0]   count_q, count_d;
    logic                      do_wr, do_rd;

    // A write into a full FIFO is dropped so the pointers never cross.
    assign do_wr = wr_en_i && (count_q != DEPTH_C);
    assign do_rd = rd_en_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + MAX_DEPTH_BITS'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + MAX_DEPTH_BITS'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (MAX_DEPTH_BITS + 1)'(1);
            2'b01:   count_d = count_q - (MAX_DEPTH_BITS + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o        = mem_q[rd_ptr_q];
    assign empty_o       = (count_q == '0);
    assign nearly_full_o = (count_q >= NF_LVL);

endmodule

// File: rtl/pkt_rate_shaper.sv
// Token-bucket packet-rate limiter: one token per packet, taken at its first
// word; packets without a token wait in the input FIFO behind backpressure.
module pkt_rate_shaper
    import pkt_rate_shaper_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int BUCKET_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic                  rate_enable,
    input  logic [15:0]           refill_period,
    input  logic                  clear_stats,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  stall_count,
    output logic [TOK_WIDTH-1:0]  tokens,
    output shaper_state_e         dbg_state_o
);

    localparam int                   FIFO_W  = CTRL_WIDTH + DATA_WIDTH;
    localparam logic [TOK_WIDTH-1:0] TOK_MAX = TOK_WIDTH'(BUCKET_MAX);

    // Handshakes: upstream may assert in_wr only in cycles where in_rdy is high;
    // downstream takes a word in every cycle out_wr is high, and out_wr is never
    // raised unless out_rdy is already high in that cycle.

    logic [FIFO_W-1:0]     fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_nearly_full;
    logic                  fifo_rd_en;
    logic [CTRL_WIDTH-1:0] head_ctrl;
    logic                  head_is_ctrl;

    shaper_state_e         state_q, state_d;
    logic [TOK_WIDTH-1:0]  tokens_q, tokens_d;
    logic [15:0]           refill_cnt_q, refill_cnt_d;
    logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
    logic [CNT_WIDTH-1:0]  stall_count_q, stall_count_d;

    logic                  allow;
    logic                  charge;
    logic                  pkt_inc;
    logic                  stall_inc;
    logic                  refill;

    fallthrough_small_fifo #(
        .WIDTH          (FIFO_W),
        .MAX_DEPTH_BITS (MAX_DEPTH_BITS)
    ) u_in_fifo (
        .clk_i         (clk),
        .reset_i       (reset),
        .din_i         ({in_ctrl, in_data}),
        .wr_en_i       (in_wr),
        .rd_en_i       (fifo_rd_en),
        .dout_o        (fifo_dout),
        .nearly_full_o (fifo_nearly_full),
        .empty_o       (fifo_empty)
    );

    assign head_ctrl    = fifo_dout[DATA_WIDTH +: CTRL_WIDTH];
    assign head_is_ctrl = |head_ctrl;

    always_comb begin
        state_d    = state_q;
        allow      = 1'b0;
        charge     = 1'b0;
        pkt_inc    = 1'b0;
        stall_inc  = 1'b0;
        fifo_rd_en = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && head_is_ctrl) begin
                    if (!rate_enable || (tokens_q != '0)) begin
                        allow = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    allow = 1'b1;
                end
            end
            ST_HOLD: begin
                stall_inc = 1'b1;
                if ((tokens_q != '0) || !rate_enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR:  allow = 1'b1;
            ST_BODY: allow = 1'b1;
        endcase

        fifo_rd_en = !fifo_empty && out_rdy && allow;

        // Transitions that depend on a word actually leaving this cycle.
        case (state_q)
            ST_IDLE: begin
                if (fifo_rd_en && head_is_ctrl) begin
                    state_d = ST_HDR;
                    pkt_inc = 1'b1;
                    charge  = rate_enable;
                end
            end
            ST_HDR: begin
                if (fifo_rd_en && !head_is_ctrl) begin
                    state_d = ST_BODY;
                end
            end
            ST_BODY: begin
                if (fifo_rd_en && head_is_ctrl) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        refill       = (refill_cnt_q >= refill_period);
        refill_cnt_d = refill ? 16'd0 : refill_cnt_q + 16'd1;

        // Refill and charge in the same cycle cancel, including at the cap.
        case ({refill, charge})
            2'b10:   tokens_d = tok_sat_inc(tokens_q, TOK_MAX);
            2'b01:   tokens_d = tokens_q - TOK_WIDTH'(1);
            default: tokens_d = tokens_q;
        endcase

        pkt_count_d = pkt_count_q;
        if (clear_stats) begin
            pkt_count_d = '0;
        end else if (pkt_inc) begin
            pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
        end

        stall_count_d = stall_count_q;
        if (clear_stats) begin
            stall_count_d = '0;
        end else if (stall_inc) begin
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            tokens_q      <= TOK_MAX;
            refill_cnt_q  <= 16'd0;
            pkt_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            tokens_q      <= tokens_d;
            refill_cnt_q  <= refill_cnt_d;
            pkt_count_q   <= pkt_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign in_rdy      = !fifo_nearly_full;
    assign out_wr      = fifo_rd_en;
    assign out_data    = fifo_dout[DATA_WIDTH-1:0];
    assign out_ctrl    = head_ctrl;
    assign pkt_count   = pkt_count_q;
    assign stall_count = stall_count_q;
    assign tokens      = tokens_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pkt_rate_shaper.sv
// Directed-plus-random bench for pkt_rate_shaper: word scoreboard, token and
// stall expectations derived from the refill period and observed packet ends.
module tb_pkt_rate_shaper;
    import pkt_rate_shaper_pkg::*;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int BM = 8;
    localparam int P2 = 1000;

    logic          clk;
    logic          reset;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          in_wr;
    logic          in_rdy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_wr;
    logic          out_rdy;
    logic          rate_enable;
    logic [15:0]   refill_period;
    logic          clear_stats;
    logic [31:0]   pkt_count;
    logic [31:0]   stall_count;
    logic [7:0]    tokens;
    shaper_state_e dbg_state;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [CW+DW-1:0] exp_q[$];
    int            eop_cyc[$];
    int            hdr_cyc[$];
    int            cyc = 0;
    bit            saw_not_rdy;
    bit            tok_fixed;
    bit            tog_done;
    int            wn;
    int            c8, c9;
    int            exp_stall;

    pkt_rate_shaper #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .BUCKET_MAX(BM)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_ctrl       (in_ctrl),
        .in_wr         (in_wr),
        .in_rdy        (in_rdy),
        .out_data      (out_data),
        .out_ctrl      (out_ctrl),
        .out_wr        (out_wr),
        .out_rdy       (out_rdy),
        .rate_enable   (rate_enable),
        .refill_period (refill_period),
        .clear_stats   (clear_stats),
        .pkt_count     (pkt_count),
        .stall_count   (stall_count),
        .tokens        (tokens),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- clock / reset-relative cycle counter ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (!in_rdy) saw_not_rdy = 1'b1;
            chk("tokens_le_max", 72'(tokens <= 8'(BM)), 72'd1);
            if (tok_fixed) chk("tokens_const", 72'(tokens), 72'(BM));
            if (out_wr) begin
                chk("out_wr_needs_rdy", 72'(out_rdy), 72'd1);
                chk("sb_word_expected", 72'(exp_q.size() != 0), 72'd1);
                if (exp_q.size() != 0) chk("sb_word", {out_ctrl, out_data}, exp_q.pop_front());
                if (out_ctrl == 8'hFF) hdr_cyc.push_back(cyc);
                if (out_ctrl == 8'h80) eop_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic put_word(input logic [CW-1:0] c, input logic [DW-1:0] d);
        int g = 0;
        while (!in_rdy && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        chk("in_rdy_wait", 72'(in_rdy), 72'd1);
        in_ctrl = c;
        in_data = d;
        in_wr   = 1'b1;
        exp_q.push_back({c, d});
        @(posedge clk); #1;
        in_wr   = 1'b0;
    endtask

    task automatic send_pkt(input int nbody);
        put_word(8'hFF, rnd64());
        for (int i = 0; i < nbody; i++) put_word(8'h00, rnd64());
        put_word(8'h80, rnd64());
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 72'(exp_q.size()), 72'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; in_wr = 1'b0; in_data = '0; in_ctrl = '0; out_rdy = 1'b1;
        rate_enable = 1'b0; refill_period = 16'(P2); clear_stats = 1'b0;
        tok_fixed = 1'b0; saw_not_rdy = 1'b0; tog_done = 1'b0; exp_stall = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_wr", 72'(out_wr), 72'd0);
        chk("rst_pkt_count", 72'(pkt_count), 72'd0);
        chk("rst_stall_count", 72'(stall_count), 72'd0);
        chk("rst_tokens", 72'(tokens), 72'(BM));
        chk("rst_state", 72'(dbg_state), 72'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_rdy", 72'(in_rdy), 72'd1);

        // Pass-through: no charge, no stalls.
        for (int p = 0; p < 3; p++) send_pkt(4);
        drain(200);
        chk("pt_pkt_count", 72'(pkt_count), 72'd3);
        chk("pt_tokens", 72'(tokens), 72'(BM));
        chk("pt_stall_count", 72'(stall_count), 72'd0);
        chk("pt_state_idle", 72'(dbg_state), 72'd0);

        // Rate limited burst from a fresh reset so refill times are known:
        // k-th refill becomes visible in cycle k*(P2+1).
        rate_enable = 1'b1; refill_period = 16'(P2);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        eop_cyc.delete(); hdr_cyc.delete(); saw_not_rdy = 1'b0;
        reset = 1'b0;
        fork
            begin
                for (int p = 0; p < 10; p++) send_pkt(4);
            end
            begin
                wn = 0;
                while (eop_cyc.size() < 8 && wn < 3000) begin @(posedge clk); #1; wn++; end
                repeat (3) @(posedge clk);
                #1;
                chk("burst_tokens_empty", 72'(tokens), 72'd0);
                chk("burst_eight_passed", 72'(pkt_count), 72'd8);
                c8 = (eop_cyc.size() >= 8) ? eop_cyc[7] : -1;
                wn = 0;
                while (hdr_cyc.size() < 9 && wn < 3000) begin @(posedge clk); #1; wn++; end
                chk("pkt9_release_cycle", 72'((hdr_cyc.size() >= 9) ? hdr_cyc[8] : -1), 72'(P2 + 2));
                chk("pkt9_stall_count", 72'(stall_count), 72'(P2 + 1 - c8 - 1));
                chk("pkt9_tokens", 72'(tokens), 72'd0);
                chk("pkt9_pkt_count", 72'(pkt_count), 72'd9);
            end
        join
        drain(3000);
        c9 = (eop_cyc.size() >= 9) ? eop_cyc[8] : -1;
        exp_stall = (P2 + 1 - c8 - 1) + (2 * (P2 + 1) - c9 - 1);
        chk("pkt10_release_cycle", 72'((hdr_cyc.size() >= 10) ? hdr_cyc[9] : -1), 72'(2 * (P2 + 1) + 1));
        chk("burst_pkt_count", 72'(pkt_count), 72'd10);
        chk("burst_stall_total", 72'(stall_count), 72'(exp_stall));
        chk("burst_backpressure", 72'(saw_not_rdy), 72'd1);

        // Continuous refill: bucket refills to the cap, then charge and refill cancel.
        refill_period = 16'd0;
        repeat (20) @(posedge clk);
        #1;
        chk("cont_refilled", 72'(tokens), 72'(BM));
        tok_fixed = 1'b1;
        for (int p = 0; p < 3; p++) send_pkt($urandom_range(1, 4));
        drain(200);
        tok_fixed = 1'b0;
        chk("cont_tokens", 72'(tokens), 72'(BM));
        chk("cont_no_stall", 72'(stall_count), 72'(exp_stall));
        chk("cont_pkt_count", 72'(pkt_count), 72'd13);

        // Partial drain then saturation: at most one refill lands during the
        // short burst, and a long idle gap must refill to exactly the cap.
        refill_period = 16'd20;
        for (int p = 0; p < 4; p++) send_pkt(1);
        drain(100);
        chk("sat_after_burst", 72'(tokens >= 8'd4 && tokens <= 8'd5), 72'd1);
        repeat (250) @(posedge clk);
        #1;
        chk("sat_tokens_cap", 72'(tokens), 72'(BM));
        chk("sat_pkt_count", 72'(pkt_count), 72'd17);

        // out_rdy toggling every cycle: order kept, each packet charged once.
        refill_period = 16'(P2);
        repeat (2) @(posedge clk);
        #1;
        tog_done = 1'b0;
        fork
            begin
                send_pkt($urandom_range(1, 4));
                send_pkt($urandom_range(1, 4));
                drain(400);
                tog_done = 1'b1;
            end
            begin
                while (!tog_done) begin @(posedge clk); #1; out_rdy = ~out_rdy; end
            end
        join
        out_rdy = 1'b1;
        chk("tog_tokens", 72'(tokens), 72'(BM - 2));
        chk("tog_pkt_count", 72'(pkt_count), 72'd19);
        chk("tog_stall", 72'(stall_count), 72'(exp_stall));

        // clear_stats in the same cycle as a packet start, then reset mid-BODY.
        out_rdy = 1'b0;
        put_word(8'hFF, rnd64());
        out_rdy = 1'b1;
        clear_stats = 1'b1;
        @(posedge clk); #1;
        clear_stats = 1'b0;
        chk("clr_pkt_count", 72'(pkt_count), 72'd0);
        chk("clr_stall_count", 72'(stall_count), 72'd0);
        chk("clr_tokens_charged", 72'(tokens), 72'(BM - 3));
        chk("clr_state_hdr", 72'(dbg_state), 72'd1);
        put_word(8'h00, rnd64());
        @(posedge clk); #1;
        out_rdy = 1'b0;
        put_word(8'h00, rnd64());
        chk("mid_state_body", 72'(dbg_state), 72'd2);
        reset = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b1;
        exp_q.delete();
        chk("mid_rst_out_wr", 72'(out_wr), 72'd0);
        chk("mid_rst_tokens", 72'(tokens), 72'(BM));
        chk("mid_rst_pkt_count", 72'(pkt_count), 72'd0);
        chk("mid_rst_in_rdy", 72'(in_rdy), 72'd1);
        reset = 1'b0;
        send_pkt(2);
        drain(100);
        chk("post_rst_pkt_count", 72'(pkt_count), 72'd1);
        chk("post_rst_tokens", 72'(tokens), 72'(BM - 1));
        chk("post_rst_stall", 72'(stall_count), 72'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
